// File: rtl/aes_block_gearbox.sv
`default_nettype none
// ============================================================================
// Module  : aes_block_gearbox
// Purpose : Gathers WORDS_PER_BLOCK stream words into one AES block, applies
//           an optional AddRoundKey XOR, then streams the block back out as
//           words. Both sides use valid/ready handshakes; filling and
//           draining never overlap.
// Rev     : 1.0  initial release
// ============================================================================
module aes_block_gearbox #(
  parameter int unsigned WORD_W          = 32,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned CNT_W           = 16,
  localparam int unsigned BLOCK_W        = WORD_W * WORDS_PER_BLOCK
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [WORD_W-1:0]   in_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [WORD_W-1:0]   out_data_o,
  output logic [WORD_W/8-1:0] out_strb_o,
  input  logic [BLOCK_W-1:0]  key_i,
  input  logic                xor_en_i,
  output logic                busy_o,
  output logic [CNT_W-1:0]    block_cnt_o
);

  // Index width covers word positions 0..WORDS_PER_BLOCK-1.
  localparam int unsigned IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PROC  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e state_q;
  state_e state_d;

  // Block buffer, word 0 in the least significant position.
  logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] buffer;
  logic [IDX_W-1:0]                       wr_idx;
  logic [IDX_W-1:0]                       rd_idx;
  logic [CNT_W-1:0]                       block_cnt;

  logic in_fire;
  logic out_fire;
  logic last_wr;
  logic last_rd;

  assign last_wr  = (wr_idx == LAST_IDX);
  assign last_rd  = (rd_idx == LAST_IDX);
  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  // State register; soft clear returns to FILL just like reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FILL;
    end else if (clear_i) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; PROC always lasts a single cycle.
  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      FILL: begin
        in_ready_o = 1'b1;
        if (in_valid_i && last_wr) begin
          state_d = PROC;
        end
      end
      PROC: begin
        state_d = DRAIN;
      end
      DRAIN: begin
        out_valid_o = 1'b1;
        if (out_ready_i && last_rd) begin
          state_d = FILL;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // Datapath: word capture, AddRoundKey, read pointer and block counter.
  // Clear wins over any handshake seen in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buffer    <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      block_cnt <= '0;
    end else if (clear_i) begin
      buffer    <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      block_cnt <= '0;
    end else begin
      if (in_fire) begin
        buffer[wr_idx] <= in_data_i;
        wr_idx         <= last_wr ? '0 : wr_idx + IDX_W'(1);
      end
      if (state_q == PROC) begin
        // key_i and xor_en_i only matter during this single cycle.
        if (xor_en_i) begin
          buffer <= buffer ^ key_i;
        end
        rd_idx <= '0;
      end
      if (out_fire) begin
        rd_idx <= last_rd ? '0 : rd_idx + IDX_W'(1);
        if (last_rd) begin
          block_cnt <= block_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Output word is a combinational mux so it stays stable under backpressure.
  assign out_data_o  = (state_q == DRAIN) ? buffer[rd_idx] : '0;
  assign out_strb_o  = (state_q == DRAIN) ? '1 : '0;
  assign busy_o      = (state_q != FILL) || (wr_idx != '0);
  assign block_cnt_o = block_cnt;

endmodule
`default_nettype wire

// File: tb/tb_aes_block_gearbox.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_block_gearbox
// Purpose : Directed self-checking bench for aes_block_gearbox (default
//           geometry plus a 64-bit x 2-word instance with a 2-bit counter).
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_aes_block_gearbox;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [3:0]    out_strb;
  logic [127:0]  key;
  logic          xor_en;
  logic          busy;
  logic [15:0]   block_cnt;

  logic          p_clear;
  logic          p_in_valid;
  logic          p_in_ready;
  logic [63:0]   p_in_data;
  logic          p_out_valid;
  logic          p_out_ready;
  logic [63:0]   p_out_data;
  logic [7:0]    p_out_strb;
  logic [127:0]  p_key;
  logic          p_xor_en;
  logic          p_busy;
  logic [1:0]    p_block_cnt;

  int total;
  int bad;

  aes_block_gearbox dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_strb_o  (out_strb),
    .key_i       (key),
    .xor_en_i    (xor_en),
    .busy_o      (busy),
    .block_cnt_o (block_cnt)
  );

  aes_block_gearbox #(
    .WORD_W          (64),
    .WORDS_PER_BLOCK (2),
    .CNT_W           (2)
  ) dut_p (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (p_clear),
    .in_valid_i  (p_in_valid),
    .in_ready_o  (p_in_ready),
    .in_data_i   (p_in_data),
    .out_valid_o (p_out_valid),
    .out_ready_i (p_out_ready),
    .out_data_o  (p_out_data),
    .out_strb_o  (p_out_strb),
    .key_i       (p_key),
    .xor_en_i    (p_xor_en),
    .busy_o      (p_busy),
    .block_cnt_o (p_block_cnt)
  );

  // 10 ns clock; stimulus and sampling both happen on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Presents four words back to back; returns in the PROC cycle.
  task automatic send4(input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      step();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Checks four output words with out_ready high; returns back in FILL.
  task automatic drain4(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                        input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_valid"}, 128'(out_valid), 128'd1);
      chk({tag, "_data"}, 128'(out_data), 128'(e[i]));
      step();
    end
    chk({tag, "_in_ready_after"}, 128'(in_ready), 128'd1);
    chk({tag, "_valid_after"}, 128'(out_valid), 128'd0);
  endtask

  initial begin
    logic [63:0] pd0;
    logic [63:0] pd1;
    logic [1:0]  cnt_exp [5];
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    clear       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b1;
    key         = '0;
    xor_en      = 1'b0;
    p_clear     = 1'b0;
    p_in_valid  = 1'b0;
    p_in_data   = '0;
    p_out_ready = 1'b1;
    p_key       = '0;
    p_xor_en    = 1'b0;
    cnt_exp[0] = 2'd1; cnt_exp[1] = 2'd2; cnt_exp[2] = 2'd3;
    cnt_exp[3] = 2'd0; cnt_exp[4] = 2'd1;

    // Reset state.
    step(); step();
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", 128'(out_data), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_cnt", 128'(block_cnt), 128'd0);
    rst_n = 1'b1;
    step();

    // Pass-through; a stray xor_en during FILL must not matter.
    xor_en = 1'b1;
    key    = {128{1'b1}};
    send4(32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
    xor_en = 1'b0;
    chk("pt_proc_valid", 128'(out_valid), 128'd0);
    chk("pt_proc_in_ready", 128'(in_ready), 128'd0);
    chk("pt_proc_busy", 128'(busy), 128'd1);
    step();
    xor_en = 1'b1;
    chk("pt_strb", 128'(out_strb), 128'hF);
    drain4("pt", 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
    chk("pt_cnt", 128'(block_cnt), 128'd1);

    // AddRoundKey.
    xor_en = 1'b0;
    key    = '0;
    send4(32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
    xor_en = 1'b1;
    key    = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;
    step();
    xor_en = 1'b0;
    key    = '0;
    drain4("ark", 32'h03020100, 32'hF8F9FAFB, 32'h0B0A0908, 32'hF0F1F2F3);
    chk("ark_cnt", 128'(block_cnt), 128'd2);

    // Backpressure at rd_idx=1; a valid input word during the stall is ignored.
    send4(32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
    step();
    chk("bp_w0", 128'(out_data), 128'h03020100);
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_data", 128'(out_data), 128'h07060504);
      chk("bp_hold_valid", 128'(out_valid), 128'd1);
      chk("bp_hold_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    in_data  = '0;
    out_ready = 1'b1;
    step();
    chk("bp_w2", 128'(out_data), 128'h0B0A0908);
    step();
    chk("bp_w3", 128'(out_data), 128'h0F0E0D0C);
    chk("bp_in_ready_last", 128'(in_ready), 128'd0);
    step();
    chk("bp_in_ready_after", 128'(in_ready), 128'd1);
    chk("bp_busy_after", 128'(busy), 128'd0);
    chk("bp_cnt", 128'(block_cnt), 128'd3);

    // Input gaps 1,0,0,1,0,1,1; the fifth word waits for the drain to finish.
    in_valid = 1'b1; in_data = 32'hA0000000; step();
    in_valid = 1'b0; in_data = 32'h11111111; step();
    step();
    in_valid = 1'b1; in_data = 32'hA0000001; step();
    in_valid = 1'b0; in_data = 32'h22222222; step();
    in_valid = 1'b1; in_data = 32'hA0000002; step();
    chk("gap_busy_mid", 128'(busy), 128'd1);
    in_data = 32'hA0000003; step();
    in_data = 32'h55555555;
    chk("gap_proc_in_ready", 128'(in_ready), 128'd0);
    step();
    drain4("gap", 32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003);
    chk("gap_cnt", 128'(block_cnt), 128'd4);
    chk("gap_busy_before_5th", 128'(busy), 128'd0);
    step();
    chk("gap_5th_taken_busy", 128'(busy), 128'd1);

    // Clear after two words; the word offered during clear is discarded.
    in_data = 32'h66666666;
    step();
    clear   = 1'b1;
    in_data = 32'h77777777;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_busy", 128'(busy), 128'd0);
    chk("clr_cnt", 128'(block_cnt), 128'd0);
    chk("clr_in_ready", 128'(in_ready), 128'd1);
    send4(32'hC0000000, 32'hC0000001, 32'hC0000002, 32'hC0000003);
    step();
    drain4("clr", 32'hC0000000, 32'hC0000001, 32'hC0000002, 32'hC0000003);
    chk("clr_cnt_after", 128'(block_cnt), 128'd1);

    // Asynchronous reset mid-DRAIN.
    send4(32'hE0000000, 32'hE0000001, 32'hE0000002, 32'hE0000003);
    step();
    step();
    chk("arst_pre_valid", 128'(out_valid), 128'd1);
    chk("arst_pre_data", 128'(out_data), 128'hE0000001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 128'(out_valid), 128'd0);
    chk("arst_data", 128'(out_data), 128'd0);
    chk("arst_in_ready", 128'(in_ready), 128'd1);
    chk("arst_cnt", 128'(block_cnt), 128'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_busy", 128'(busy), 128'd0);

    // 64-bit x 2-word instance, 2-bit counter, alternating AddRoundKey.
    p_key = {64'hF0F0F0F0_F0F0F0F0, 64'h0F0F0F0F_0F0F0F0F};
    for (int b = 0; b < 5; b++) begin
      pd0 = 64'h1111_0000_0000_0000 + 64'(b * 2);
      pd1 = 64'h2222_0000_0000_0000 + 64'(b * 2 + 1);
      p_xor_en   = b[0];
      p_in_valid = 1'b1;
      p_in_data  = pd0;
      step();
      p_in_data  = pd1;
      step();
      p_in_valid = 1'b0;
      chk("p_proc_valid", 128'(p_out_valid), 128'd0);
      step();
      chk("p_w0", 128'(p_out_data), 128'(b[0] ? (pd0 ^ 64'h0F0F0F0F_0F0F0F0F) : pd0));
      chk("p_strb", 128'(p_out_strb), 128'hFF);
      step();
      chk("p_w1", 128'(p_out_data), 128'(b[0] ? (pd1 ^ 64'hF0F0F0F0_F0F0F0F0) : pd1));
      step();
      chk("p_cnt", 128'(p_block_cnt), 128'(cnt_exp[b]));
      chk("p_in_ready", 128'(p_in_ready), 128'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
